// File: rtl/mac_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mac_seq_ctrl
//
// Sequencer for the signed 8x8 MAC of the SNN datapath. On `start` it
// computes one fully-connected layer of NUM_OUT neurons. Each neuron is the
// dot product of NUM_IN signed 8-bit inputs with signed 8-bit weights. The
// block issues input-RAM and weight-ROM read addresses, feeds the returned
// operands to the external MAC, clears the MAC between neurons, and writes a
// scaled and saturated 8-bit result per neuron to the output buffer.
//
// Optional feature (compile-time macro MAC_SEQ_RELU_EN):
//   defined     : ReLU clamp to 0..127 (unsigned result)
//   not defined : signed saturation to -128..127 (two's complement result)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      begin a layer (sampled only while idle)
//   busy       high from the cycle after start is accepted to the last write
//   done       one-cycle pulse coincident with the last out_we
//   in_addr    input RAM read address (data returns one cycle later)
//   in_data    input RAM read data, signed
//   wt_addr    weight ROM address n*NUM_IN+i (data returns one cycle later)
//   wt_data    weight ROM read data, signed
//   mac_in1/2  MAC operands, zero whenever no valid data is returning
//   mac_clr_n  MAC synchronous clear, active low
//   mac_acc    MAC accumulator, signed 26 bit
//   out_we     output buffer write strobe
//   out_addr   neuron index being written
//   out_data   activated result, zero when out_we is low
// -----------------------------------------------------------------------------
module mac_seq_ctrl #(
  parameter int  NUM_IN  = 784,
  parameter int  NUM_OUT = 32,
  parameter int  SHIFT   = 8,
  localparam int IADDR_W = $clog2(NUM_IN),
  localparam int WADDR_W = $clog2(NUM_IN * NUM_OUT),
  localparam int OADDR_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [IADDR_W-1:0] in_addr,
  input  logic [7:0]         in_data,
  output logic [WADDR_W-1:0] wt_addr,
  input  logic [7:0]         wt_data,
  output logic [7:0]         mac_in1,
  output logic [7:0]         mac_in2,
  output logic               mac_clr_n,
  input  logic [25:0]        mac_acc,
  output logic               out_we,
  output logic [OADDR_W-1:0] out_addr,
  output logic [7:0]         out_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_WRITE
  } state_e;

  localparam logic [IADDR_W-1:0] LAST_I = IADDR_W'(NUM_IN - 1);
  localparam logic [OADDR_W-1:0] LAST_N = OADDR_W'(NUM_OUT - 1);

  state_e               state_q,    state_d;
  logic [OADDR_W-1:0]   n_q,        n_d;
  logic [IADDR_W-1:0]   in_addr_q,  in_addr_d;
  logic [WADDR_W-1:0]   wt_addr_q,  wt_addr_d;
  logic                 vld_q,      vld_d;
  logic                 busy_q,     busy_d;
  logic                 done_q,     done_d;
  logic                 clr_n_q,    clr_n_d;
  logic                 out_we_q,   out_we_d;
  logic [OADDR_W-1:0]   out_addr_q, out_addr_d;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic. All outputs except the operand mux and
  // the activation are registered, so each one is computed here for the cycle
  // the FSM is about to enter.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    n_d        = n_q;
    in_addr_d  = in_addr_q;
    wt_addr_d  = wt_addr_q;
    vld_d      = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    clr_n_d    = clr_n_q;
    out_we_d   = 1'b0;
    out_addr_d = '0;

    unique case (state_q)
      S_IDLE: begin
        n_d       = '0;
        in_addr_d = '0;
        wt_addr_d = '0;
        busy_d    = 1'b0;
        clr_n_d   = 1'b0;
        if (start) begin
          state_d = S_ISSUE;
          busy_d  = 1'b1;
          clr_n_d = 1'b1;
        end
      end

      S_ISSUE: begin
        // An address goes out this cycle, so its data is valid next cycle.
        vld_d = 1'b1;
        if (in_addr_q == LAST_I) begin
          state_d = S_DRAIN;
        end else begin
          in_addr_d = in_addr_q + 1'b1;
          // Running weight address replaces the n*NUM_IN+i multiply.
          wt_addr_d = wt_addr_q + 1'b1;
        end
      end

      S_DRAIN: begin
        state_d    = S_WRITE;
        clr_n_d    = 1'b0;
        out_we_d   = 1'b1;
        out_addr_d = n_q;
        done_d     = (n_q == LAST_N);
      end

      S_WRITE: begin
        in_addr_d = '0;
        if (n_q == LAST_N) begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          n_d       = '0;
          wt_addr_d = '0;
        end else begin
          state_d   = S_ISSUE;
          n_d       = n_q + 1'b1;
          // Weight address of the last issue was n*NUM_IN+NUM_IN-1; one more
          // step lands on the first weight of neuron n+1.
          wt_addr_d = wt_addr_q + 1'b1;
          clr_n_d   = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; the reset is in the sensitivity list so outputs drop
  // the moment rst rises, not at the next clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      in_addr_q  <= '0;
      wt_addr_q  <= '0;
      vld_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      clr_n_q    <= 1'b0;
      out_we_q   <= 1'b0;
      out_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      in_addr_q  <= in_addr_d;
      wt_addr_q  <= wt_addr_d;
      vld_q      <= vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      clr_n_q    <= clr_n_d;
      out_we_q   <= out_we_d;
      out_addr_q <= out_addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Activation: arithmetic shift, then clamp to the 8-bit output range.
  // ---------------------------------------------------------------------------
  logic signed [25:0] acc_shifted;
  logic [7:0]         act;

  assign acc_shifted = $signed(mac_acc) >>> SHIFT;

  always_comb begin
    act = acc_shifted[7:0];
`ifdef MAC_SEQ_RELU_EN
    if (acc_shifted < 26'sd0) begin
      act = 8'd0;
    end else if (acc_shifted > 26'sd127) begin
      act = 8'd127;
    end
`else
    if (acc_shifted > 26'sd127) begin
      act = 8'h7F;
    end else if (acc_shifted < -26'sd128) begin
      act = 8'h80;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Outputs. Operands are forced to zero whenever no read data is returning,
  // because the MAC accumulates on every edge while its clear is released.
  // ---------------------------------------------------------------------------
  assign busy      = busy_q;
  assign done      = done_q;
  assign in_addr   = in_addr_q;
  assign wt_addr   = wt_addr_q;
  assign mac_clr_n = clr_n_q;
  assign mac_in1   = vld_q ? in_data : 8'd0;
  assign mac_in2   = vld_q ? wt_data : 8'd0;
  assign out_we    = out_we_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_we_q ? act : 8'd0;

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencer for the signed 8x8 MAC in the SNN datapath: on `start` it computes one fully-connected layer of `NUM_OUT` neurons, each a dot product of `NUM_IN` signed 8-bit inputs with signed 8-bit weights. It issues input-RAM and weight-ROM read addresses, feeds the returned operands to the MAC, clears the MAC between neurons, and scales and saturates each 26-bit accumulator into an 8-bit result written to the output buffer.

## Interface
- `NUM_IN`, 784, inputs per neuron (≥2)
- `NUM_OUT`, 32, neurons per layer (≥1)
- `SHIFT`, 8, arithmetic right shift applied to the accumulator before saturation (0..17)
- Derived: `IADDR_W`=$clog2(NUM_IN), `WADDR_W`=$clog2(NUM_IN*NUM_OUT), `OADDR_W`=max(1,$clog2(NUM_OUT))
- `clk` in 1: rising-edge clock
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: begin a layer; sampled only in IDLE
- `busy` out 1: high from the cycle after `start` is accepted through the final WRITE cycle
- `done` out 1: single-cycle pulse, coincident with the last `out_we`
- `in_addr` out IADDR_W: input RAM read address (registered)
- `in_data` in 8 signed: input RAM data, valid one cycle after `in_addr`
- `wt_addr` out WADDR_W: weight ROM address = n*NUM_IN+i (registered)
- `wt_data` in 8 signed: weight ROM data, valid one cycle after `wt_addr`
- `mac_in1`, `mac_in2` out 8 signed: MAC operands
- `mac_clr_n` out 1: MAC synchronous clear, active low
- `mac_acc` in 26 signed: MAC accumulator
- `out_we` out 1: output buffer write strobe
- `out_addr` out OADDR_W: neuron index n
- `out_data` out 8: activated result

## Operation
- MAC contract: on every rising edge with `mac_clr_n`=1, acc += in1*in2. Idle operands must therefore be 0.
- FSM states: IDLE, ISSUE, DRAIN, WRITE.
- IDLE: `mac_clr_n`=0 and operands 0. `start` → ISSUE with i=0 and n=0.
- ISSUE: drive `in_addr`=i and `wt_addr`=n*NUM_IN+i. Use a running counter for `wt_addr`, not a multiplier. i increments each cycle; after i=NUM_IN-1 → DRAIN.
- A registered `vld` flag is set each cycle an address was issued. `mac_in1`/`mac_in2` = `in_data`/`wt_data` when `vld`=1, otherwise 0. `mac_clr_n`=1 in ISSUE and DRAIN.
- DRAIN: the last operand pair is applied; no address is issued. → WRITE.
- WRITE: `out_we`=1, `out_addr`=n, `out_data`=act(`mac_acc`), and `mac_clr_n`=0 so the MAC clears at the end of the cycle.
  - If n<NUM_OUT-1: n++, i=0 → ISSUE.
  - Otherwise: `done`=1 → IDLE.
- act(): s = `mac_acc` >>> SHIFT (signed). Then the configuration-dependent clamp below.
- `start` outside IDLE, including during the `done` cycle, is ignored. `start` in the cycle after `done` is accepted.
- `out_data`=0 whenever `out_we`=0.

## Timing
- `start` sampled high in cycle 0 → ISSUE in cycles 1..NUM_IN, DRAIN in cycle NUM_IN+1, WRITE in cycle NUM_IN+2.
- Neuron n writes in cycle (n+1)(NUM_IN+2). Total latency from start to `done` = NUM_OUT*(NUM_IN+2).
- The product of address i reaches the accumulator at the edge ending cycle i+2 of that neuron.
- Reset values: `busy`=0, `done`=0, `in_addr`=0, `wt_addr`=0, `mac_in1`=0, `mac_in2`=0, `mac_clr_n`=0, `out_we`=0, `out_addr`=0, `out_data`=0, state=IDLE, `vld`=0.
- Reset mid-layer: outputs go to reset values immediately (asynchronously). No further `out_we` or `done` is produced. A partial layer is abandoned and the MAC is cleared on the next clock edge.

## Configuration
- `MAC_SEQ_RELU_EN` defined: ReLU. s<0 → 0; s>127 → 127; otherwise s. `out_data` is unsigned 0..127.
- `MAC_SEQ_RELU_EN` not defined: signed saturation of s to [-128,127], two's-complement output.

## Test plan
All scenarios use NUM_IN=4, NUM_OUT=2, SHIFT=0 unless stated.
- Basic dot product: inputs {2,-2,-3,1}, weights n0 {5,5,8,0}, n1 {1,1,1,1} → acc -24 and -2. Without RELU: `out_data` -24 (0xE8) and -2 (0xFE). With RELU: 0 and 0.
- Positive saturation: all inputs 127, all weights 127 → acc 64516 → `out_data`=127 for both neurons in both configurations. With SHIFT=9: s=126 → 126.
- Negative saturation: inputs 127, weights -128 → acc -65024. Without RELU → -128 (0x80). With RELU → 0.
- Cycle timing: `start` in cycle 0 → `out_we` in cycles 6 (addr 0) and 12 (addr 1). `done` only in cycle 12. `busy` high in cycles 1..12. `mac_clr_n` low in cycles 0, 6 and 12. Operands 0 in cycles 1 and 7.
- Handshake: `start` held high throughout → second layer begins in cycle 13. A `start` pulse in cycle 5 changes nothing.
- Reset mid-run: assert `rst` in cycle 3 → all outputs at reset values in the same cycle and no `out_we`. A fresh `start` then reproduces the basic dot-product results exactly.
